// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the main-memory arbiter.
//   state_t : burst sequencer states (IDLE, BURST_I, BURST_D)
//   owner_t : which cache side owns or won the memory port
//   DEF_BLOCK_WORDS : default burst length in words (one cache line)
// Optional feature macro used by the importing files: MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int DEF_BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_I = 2'd1,
    BURST_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: pure (combinational) winner selection between the I and D
// cache sides. Only meaningful when at least one request is pending; with no
// request the output is OWN_I and the caller ignores it.
//   i_req, d_req : pending requests
//   last_win     : previous grant owner (only with MEM_ARB_RR_EN)
//   win          : selected owner
// MEM_ARB_RR_EN defined   : contested grants go to the side that did not win
//                           the previous grant.
// MEM_ARB_RR_EN undefined : fixed D-over-I priority.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last_win,
`endif
  output owner_t win
);

  always_comb begin
    win = OWN_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      win = (last_win == OWN_D) ? OWN_I : OWN_D;
`else
      win = OWN_D;
`endif
    end else if (d_req) begin
      win = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache fill
// side (read only) and the D-cache side (fill or writeback). Each grant
// becomes a burst of BLOCK_WORDS single-word accesses; beats advance only on
// mem_valid, and at least one IDLE cycle separates consecutive bursts.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   i_req/i_addr                  : I-side burst request and address
//   i_rdata/i_valid/i_done        : I-side beat data, beat strobe, last beat
//   d_req/d_we/d_addr/d_wdata     : D-side request, direction, address, write word
//   d_beat                        : beat index the D side muxes d_wdata with
//   d_rdata/d_valid/d_done        : D-side beat data, beat strobe, last beat
//   mem_hsel/mem_re/mem_we        : memory select and enables
//   mem_a/mem_wd/mem_rd/mem_valid : memory address, write/read data, beat ack
// Optional macro MEM_ARB_RR_EN: alternating priority on contested grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  localparam int BEAT_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [BEAT_W-1:0] d_beat,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_done,
  output logic              mem_hsel,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  input  logic              mem_valid
);

  // Byte-offset bits inside one block; cleared when the base is latched so
  // OR-ing in the beat index can never carry into the bits above the block.
  localparam logic [31:0]       OFF_MASK  = 32'(BLOCK_WORDS * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  state_t            state;
  logic [31:0]       base;
  logic              wr;
  logic [BEAT_W-1:0] beat;
  owner_t            win;

  logic burst, is_i, is_d, wr_cyc, last;

`ifdef MEM_ARB_RR_EN
  owner_t last_win;

  mem_arb_prio u_prio (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_win (last_win),
    .win      (win)
  );
`else
  mem_arb_prio u_prio (
    .i_req (i_req),
    .d_req (d_req),
    .win   (win)
  );
`endif

  // Burst sequencer: grant in IDLE, then walk the beats on mem_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
      wr    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_win <= OWN_I;   // I "won last", so D takes the first contest
`endif
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (i_req || d_req) begin
            state <= (win == OWN_D) ? BURST_D : BURST_I;
            base  <= ((win == OWN_D) ? d_addr : i_addr) & ~OFF_MASK;
            wr    <= (win == OWN_D) && d_we;   // I side only ever reads
`ifdef MEM_ARB_RR_EN
            last_win <= win;
`endif
          end
        end
        BURST_I, BURST_D: begin
          // Without mem_valid everything holds: address, controls, counter.
          if (mem_valid) begin
            if (beat == LAST_BEAT) begin
              state <= IDLE;
              beat  <= '0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign burst  = (state != IDLE);
  assign is_i   = (state == BURST_I);
  assign is_d   = (state == BURST_D);
  assign wr_cyc = is_d && wr;
  assign last   = (beat == LAST_BEAT);

  // Memory side: pure decode of registered state, zero while idle.
  assign mem_hsel = burst;
  assign mem_re   = burst && !wr_cyc;
  assign mem_we   = wr_cyc;
  assign mem_a    = burst ? (base | {{(30 - BEAT_W){1'b0}}, beat, 2'b00}) : '0;
  assign mem_wd   = burst ? d_wdata : '0;

  // Requester side: beat strobes follow mem_valid in the same cycle.
  assign i_valid = is_i && mem_valid;
  assign i_done  = i_valid && last;
  assign i_rdata = is_i ? mem_rd : '0;

  assign d_valid = is_d && mem_valid;
  assign d_done  = d_valid && last;
  assign d_rdata = (is_d && !wr) ? mem_rd : '0;
  assign d_beat  = is_d ? beat : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (BLOCK_WORDS = 4) ----------------
  logic        reset;
  logic        i_req, d_req, d_we, mv;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_wd, mem_rd;
  logic        i_valid, i_done, d_valid, d_done;
  logic [1:0]  d_beat;
  logic        mem_hsel, mem_re, mem_we;

  logic [31:0] mem [0:255];

  assign mem_rd  = mem[mem_a[9:2]];
  assign d_wdata = 32'hD0 + 32'(d_beat);

  always @(posedge clk)
    if (mem_hsel && mem_we && mv) mem[mem_a[9:2]] <= mem_wd;

  mem_arbiter #(.BLOCK_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_beat(d_beat),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_done(d_done),
    .mem_hsel(mem_hsel), .mem_re(mem_re), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_valid(mv)
  );

  // ---------------- second DUT (BLOCK_WORDS = 8) ----------------
  logic        w8_i_req, w8_d_req, w8_d_we, w8_mv;
  logic [31:0] w8_i_addr, w8_d_addr, w8_d_wdata;
  logic [31:0] w8_i_rdata, w8_d_rdata, w8_mem_a, w8_mem_wd, w8_mem_rd;
  logic        w8_i_valid, w8_i_done, w8_d_valid, w8_d_done;
  logic [2:0]  w8_d_beat;
  logic        w8_mem_hsel, w8_mem_re, w8_mem_we;

  assign w8_mem_rd = w8_mem_a ^ 32'h5A5A_0000;

  mem_arbiter #(.BLOCK_WORDS(8)) dut8 (
    .clk(clk), .reset(reset),
    .i_req(w8_i_req), .i_addr(w8_i_addr), .i_rdata(w8_i_rdata), .i_valid(w8_i_valid),
    .i_done(w8_i_done),
    .d_req(w8_d_req), .d_we(w8_d_we), .d_addr(w8_d_addr), .d_wdata(w8_d_wdata),
    .d_beat(w8_d_beat), .d_rdata(w8_d_rdata), .d_valid(w8_d_valid), .d_done(w8_d_done),
    .mem_hsel(w8_mem_hsel), .mem_re(w8_mem_re), .mem_we(w8_mem_we), .mem_a(w8_mem_a),
    .mem_wd(w8_mem_wd), .mem_rd(w8_mem_rd), .mem_valid(w8_mv)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        i_req, d_req, d_we;
    logic        hsel, re, we;
    logic [31:0] a, wd;
    logic        iv, idn;
    logic [31:0] ir;
    logic        dv, ddn;
    logic [31:0] dr;
    logic [1:0]  db;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nfail = 0;

  function automatic void add_idle(logic ir, logic dr, logic dw);
    vec_t v;
    v = '{i_req: ir, d_req: dr, d_we: dw, hsel: 0, re: 0, we: 0, a: 0, wd: 0,
          iv: 0, idn: 0, ir: 0, dv: 0, ddn: 0, dr: 0, db: 0};
    tv.push_back(v);
  endfunction

  // One 4-beat burst with mem_valid high every cycle.
  function automatic void add_burst(logic ir, logic dr, logic dw, logic side_d,
                                    logic write, logic [31:0] base, logic [31:0] data0);
    vec_t v;
    for (int k = 0; k < 4; k++) begin
      v.i_req = ir; v.d_req = dr; v.d_we = dw;
      v.hsel  = 1'b1;
      v.re    = !write;
      v.we    = write;
      v.a     = base + 32'(4 * k);
      v.wd    = side_d ? 32'hD0 + 32'(k) : 32'hD0;
      v.iv    = !side_d;
      v.idn   = !side_d && (k == 3);
      v.ir    = side_d ? 32'h0 : data0 + 32'(k);
      v.dv    = side_d;
      v.ddn   = side_d && (k == 3);
      v.dr    = (side_d && !write) ? data0 + 32'(k) : 32'h0;
      v.db    = side_d ? 2'(k) : 2'd0;
      tv.push_back(v);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_i_beat(input string name, input logic [31:0] a, input logic v,
                            input logic dn, input logic [31:0] rd);
    @(negedge clk);
    chk({name, " mem_a"}, mem_a, a);
    chk({name, " i_valid"}, 32'(i_valid), 32'(v));
    chk({name, " i_done"}, 32'(i_done), 32'(dn));
    if (v) chk({name, " i_rdata"}, i_rdata, rd);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    for (int k = 0; k < 4; k++) mem[8'h10 + k] = 32'hA0 + 32'(k);

    reset = 1'b1; mv = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h48; d_addr = 32'h104;
    w8_i_req = 1'b0; w8_d_req = 1'b0; w8_d_we = 1'b0; w8_mv = 1'b1;
    w8_i_addr = 32'h0; w8_d_addr = 32'h0; w8_d_wdata = 32'h0;

    // Reset state: requests pending but everything must stay quiet.
    tick();
    @(negedge clk);
    chk("rst mem_hsel", 32'(mem_hsel), 0);
    chk("rst mem_re",   32'(mem_re), 0);
    chk("rst mem_we",   32'(mem_we), 0);
    chk("rst mem_a",    mem_a, 0);
    chk("rst i_valid",  32'(i_valid), 0);
    chk("rst d_valid",  32'(d_valid), 0);
    chk("rst d_beat",   32'(d_beat), 0);
    tick();
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // Table: I fill, D writeback, two contested grants, then quiet.
    add_idle(1, 0, 0);
    add_burst(1, 0, 0, 1'b0, 1'b0, 32'h40, 32'hA0);
    add_idle(0, 1, 1);
    add_burst(0, 1, 1, 1'b1, 1'b1, 32'h100, 32'h0);
    add_idle(1, 1, 0);
`ifdef MEM_ARB_RR_EN
    // Last grant went to D (uncontested), so I takes this contest, then D.
    add_burst(1, 1, 0, 1'b0, 1'b0, 32'h40, 32'hA0);
    add_idle(1, 1, 0);
    add_burst(1, 1, 0, 1'b1, 1'b0, 32'h100, 32'hD0);
`else
    add_burst(1, 1, 0, 1'b1, 1'b0, 32'h100, 32'hD0);
    add_idle(1, 1, 0);
    add_burst(1, 1, 0, 1'b1, 1'b0, 32'h100, 32'hD0);
`endif
    add_idle(0, 0, 0);
    add_idle(0, 0, 0);

    foreach (tv[n]) begin
      i_req = tv[n].i_req; d_req = tv[n].d_req; d_we = tv[n].d_we; mv = 1'b1;
      @(negedge clk);
      chk($sformatf("row%0d mem_hsel", n), 32'(mem_hsel), 32'(tv[n].hsel));
      chk($sformatf("row%0d mem_re", n),   32'(mem_re),   32'(tv[n].re));
      chk($sformatf("row%0d mem_we", n),   32'(mem_we),   32'(tv[n].we));
      chk($sformatf("row%0d mem_a", n),    mem_a,         tv[n].a);
      chk($sformatf("row%0d mem_wd", n),   mem_wd,        tv[n].wd);
      chk($sformatf("row%0d i_valid", n),  32'(i_valid),  32'(tv[n].iv));
      chk($sformatf("row%0d i_done", n),   32'(i_done),   32'(tv[n].idn));
      chk($sformatf("row%0d i_rdata", n),  i_rdata,       tv[n].ir);
      chk($sformatf("row%0d d_valid", n),  32'(d_valid),  32'(tv[n].dv));
      chk($sformatf("row%0d d_done", n),   32'(d_done),   32'(tv[n].ddn));
      chk($sformatf("row%0d d_rdata", n),  d_rdata,       tv[n].dr);
      chk($sformatf("row%0d d_beat", n),   32'(d_beat),   32'(tv[n].db));
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Writeback landed in memory.
    for (int k = 0; k < 4; k++)
      chk($sformatf("wb mem[%0d]", 16'h40 + k), mem[8'h40 + k], 32'hD0 + 32'(k));

    // Stall: mem_valid low for 3 cycles on beat 2.
    i_req = 1'b1; i_addr = 32'h48; mv = 1'b1;
    @(negedge clk);
    chk("stall idle hsel", 32'(mem_hsel), 0);
    tick();
    chk_i_beat("stall b0", 32'h40, 1, 0, 32'hA0);
    chk_i_beat("stall b1", 32'h44, 1, 0, 32'hA1);
    mv = 1'b0;
    for (int s = 0; s < 3; s++)
      chk_i_beat($sformatf("stall hold%0d", s), 32'h48, 0, 0, 32'h0);
    mv = 1'b1;
    chk_i_beat("stall b2", 32'h48, 1, 0, 32'hA2);
    chk_i_beat("stall b3", 32'h4C, 1, 1, 32'hA3);
    i_req = 1'b0;
    @(negedge clk);
    chk("stall post hsel", 32'(mem_hsel), 0);
    tick();

    // Reset on beat 1 of a D writeback.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h180;
    tick();
    @(negedge clk);
    chk("rstmid b0 mem_we", 32'(mem_we), 1);
    chk("rstmid b0 mem_a", mem_a, 32'h180);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid b1 mem_a", mem_a, 32'h184);
    tick();
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h48;
    @(negedge clk);
    chk("rstmid after hsel", 32'(mem_hsel), 0);
    chk("rstmid after we", 32'(mem_we), 0);
    chk("rstmid after re", 32'(mem_re), 0);
    chk("rstmid after mem_a", mem_a, 0);
    chk("rstmid after mem_wd", mem_wd, 0);
    chk("rstmid after d_valid", 32'(d_valid), 0);
    chk("rstmid after d_beat", 32'(d_beat), 0);
    tick();
    chk_i_beat("rstmid I b0", 32'h40, 1, 0, 32'hA0);
    i_req = 1'b0;   // dropped mid-burst: the burst must still run out
    chk_i_beat("rstmid I b1", 32'h44, 1, 0, 32'hA1);
    chk_i_beat("rstmid I b2", 32'h48, 1, 0, 32'hA2);
    chk_i_beat("rstmid I b3", 32'h4C, 1, 1, 32'hA3);

    // BLOCK_WORDS = 8: 0x3C aligns to 0x20, beats never carry into bit 5.
    w8_d_req = 1'b1; w8_d_we = 1'b0; w8_d_addr = 32'h3C; w8_mv = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("w8 b%0d mem_a", k), w8_mem_a, 32'h20 + 32'(4 * k));
      chk($sformatf("w8 b%0d d_valid", k), 32'(w8_d_valid), 1);
      chk($sformatf("w8 b%0d d_done", k), 32'(w8_d_done), (k == 7) ? 1 : 0);
      chk($sformatf("w8 b%0d d_beat", k), 32'(w8_d_beat), 32'(k));
      chk($sformatf("w8 b%0d d_rdata", k), w8_d_rdata, (32'h20 + 32'(4 * k)) ^ 32'h5A5A_0000);
      tick();
    end
    w8_d_req = 1'b0;
    @(negedge clk);
    chk("w8 post hsel", 32'(w8_mem_hsel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates and sequences the single shared main-memory port between the instruction-cache fill side (I, read-only) and the data-cache side (D, line fill or writeback).
- Turns each granted request into a burst of BLOCK_WORDS single-word accesses, driving the memory's we/re/HSEL/address/write-data lines and returning per-beat read data and beat strobes to the owner.
- Sits between the two cache controllers and the memory model in the pipelined core.

Parameters:
- BLOCK_WORDS, 4, words per burst (cache line); power of two, 1..16.
- BEAT_W, $clog2(BLOCK_WORDS) (min 1), beat counter width (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  I-side burst request; held until i_done
- i_addr  in  32  I-side address; low bits ignored, block-aligned internally
- i_rdata  out  32  read data for current I beat
- i_valid  out  1  I beat completes this cycle
- i_done  out  1  last I beat this cycle
- d_req  in  1  D-side burst request; held until d_done
- d_we  in  1  1 = writeback burst, 0 = fill burst; sampled at grant
- d_addr  in  32  D-side address; block-aligned internally
- d_wdata  in  32  write word for beat index d_beat
- d_beat  out  BEAT_W  current beat index, for D-side write-data muxing
- d_rdata  out  32  read data for current D beat
- d_valid  out  1  D beat completes this cycle
- d_done  out  1  last D beat this cycle
- mem_hsel  out  1  memory select
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_a  out  32  memory byte address, word-aligned
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational from mem_a)
- mem_valid  in  1  memory beat acknowledge (memory Valid)

Behaviour:
- Clocking: one clock, clk; reset synchronous, active-high. All state updates on posedge clk.
- States: IDLE, BURST_I, BURST_D.
- IDLE:
  - All mem_* outputs 0; all valid/done outputs 0.
  - If any request is pending, latch the winner, its block base (addr[31:BEAT_W+2], low bits 0) and, for D, d_we. Move to BURST_x next cycle with the beat counter at 0.
- Arbitration, both requests pending: D wins (fixed priority) unless MEM_ARB_RR_EN is defined.
- BURST_x:
  - mem_hsel=1.
  - mem_re = ~write; mem_we = write (I is always read).
  - mem_a = {base, beat, 2'b00}.
  - mem_wd = d_wdata.
  - d_beat = beat (0 outside BURST_D).
- Beat completion occurs in any cycle where mem_valid=1:
  - x_valid=1 combinationally that cycle.
  - x_rdata = mem_rd on fills; 0 on writes and when idle.
  - Beat counter increments.
- Stall: if mem_valid=0, the beat holds. Address, controls and counter stay stable.
- Last beat (beat==BLOCK_WORDS-1 and mem_valid): x_done=1 the same cycle; next state is IDLE and the counter clears.
- Minimum one IDLE cycle between bursts. A request present at cycle t in IDLE gives its first beat at t+1. Back-to-back bursts: done at t+4 (BLOCK_WORDS=4), IDLE at t+5, next first beat at t+6.
- Request deasserted mid-burst: the burst still completes (requesters must not do this). A requester that keeps req high after done is treated as a new request.
- The grant never switches mid-burst. The losing request waits with no timeout.
- Reset mid-burst: next cycle IDLE, counter 0, all outputs 0, round-robin pointer cleared to favour D. No partial write is re-issued.
- Address wrap: base+beat never carries out of the block. Address bits above the block are never modified.
- Reset values: every output 0.

Optional Feature:
- MEM_ARB_RR_EN defined: a 1-bit last-winner register alternates priority when both requests are pending. The side that lost the previous contested grant wins the next one. Uncontested grants also update the register. Reset value: last winner = I, so D wins first.
- MEM_ARB_RR_EN undefined: fixed D-over-I priority, no extra register.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BURST_I, BURST_D), owner enum (OWN_I, OWN_D), default BLOCK_WORDS constant.
- One sub-module, mem_arb_prio: a pure arbiter taking i_req, d_req and the last winner, returning the winner. It holds the MEM_ARB_RR_EN variants.
- Burst sequencer FSM and counter live in mem_arbiter.

Test Plan:
- I fill, memory preloaded word[0x40..0x4C]=A0..A3, i_addr=0x48, mem_valid tied 1 → mem_a 0x40,0x44,0x48,0x4C on cycles 1-4; i_valid on cycles 1-4 with A0..A3; i_done cycle 4; mem_re=1, mem_we=0.
- D writeback, d_we=1, d_addr=0x100, d_wdata driven from d_beat as 0xD0+beat → memory 0x100..0x10C = 0xD0..0xD3; d_done on beat 3; mem_we=1 exactly 4 cycles.
- i_req and d_req both asserted at cycle 0, repeated twice → without macro: D, D. With MEM_ARB_RR_EN: D first, then I. A 1-cycle IDLE gap precedes each burst.
- mem_valid low on beat 2 for 3 cycles → mem_a held at base+8; no valid pulse during the stall; done delayed 3 cycles; data is correct.
- reset asserted on beat 1 of a D write → next cycle all outputs 0, state IDLE; a following I request starts at beat 0.
- BLOCK_WORDS=8, d_addr=0x3C → addresses 0x20..0x3C; no carry into bit 5.
